ppi_bus_master: RTL
===================

PPI_BUS_MASTER -- requirements
Module: ppi_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 1, address/data setup cycles before strobe (legal 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 2, cycles WRITE/READ held high (legal 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 1, address/data hold cycles after strobe (legal 1..15).
REQ-004 SHALL use one clock and an asynchronous, active-high reset; ports CLK and RESET.
REQ-005 Ports: CLK  in  1  clock; all state changes on its rising edge.
REQ-006 Ports: RESET  in  1  asynchronous active-high reset.
REQ-007 Ports: req_valid  in  1  host transfer request.
REQ-008 Ports: req_ready  out  1  block accepts a request this cycle.
REQ-009 Ports: req_write  in  1  1 = write cycle, 0 = read cycle.
REQ-010 Ports: req_addr  in  2  PPI register select (0 PortA, 1 PortB, 2 PortC, 3 control).
REQ-011 Ports: req_wdata  in  8  write data.
REQ-012 Ports: rsp_valid  out  1  one-cycle pulse marking transfer completion.
REQ-013 Ports: rsp_rdata  out  8  read data, valid with rsp_valid on reads.
REQ-014 Ports: ctrl_shadow  out  8  last control word written to address 3.
REQ-015 Ports: A  out  2  PPI address bus.
REQ-016 Ports: WRITE / READ  out  1 each  active-high PPI strobes.
REQ-017 Ports: DATA  inout  8  PPI data bus, tri-stated unless driving a write.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD; req_ready = 1 only in IDLE.
REQ-019 Handshake: request accepted on a rising edge where req_valid and req_ready are both 1; req_write/addr/wdata latched at that edge.
REQ-020 IDLE->SETUP on acceptance; SETUP lasts SETUP_CYC cycles, then STROBE for STROBE_CYC cycles, then HOLD for HOLD_CYC cycles, then IDLE.
REQ-021 A SHALL carry the latched address throughout SETUP, STROBE and HOLD; A = 0 in IDLE.
REQ-022 On writes, DATA SHALL be driven with latched data throughout SETUP, STROBE and HOLD; otherwise DATA = high-Z.
REQ-023 WRITE (write) or READ (read) SHALL be 1 exactly during STROBE cycles; never both; both 0 in all other states.
REQ-024 On reads, DATA SHALL be sampled at the rising edge ending the last STROBE cycle into rsp_rdata.
REQ-025 rsp_valid SHALL be 1 for exactly the first cycle in IDLE after HOLD; latency from accepting edge to rsp_valid = SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (5 at defaults).
REQ-026 rsp_rdata SHALL hold its last value until the next read completes; unchanged by writes.
REQ-027 ctrl_shadow SHALL update to the written data on completion of a write to address 3 only.
REQ-028 A new request may be accepted in the same cycle rsp_valid is high (back-to-back, no idle gap).
REQ-029 req_valid while busy SHALL be ignored, not queued; the host holds it until req_ready.
REQ-030 Phase counters SHALL be 4 bits and reload on every state transition; no wrap inside a phase.

Reset
REQ-031 RESET high SHALL immediately (asynchronously) force IDLE, WRITE = READ = 0, A = 0, DATA high-Z, rsp_valid = 0, rsp_rdata = 0, ctrl_shadow = 0.
REQ-032 Reset mid-transfer SHALL abort it with no rsp_valid; req_ready = 1 in the first cycle after RESET falls.

Verification
REQ-033 Write addr 3 data 0x80, defaults -> WRITE high cycles 2-3 after accept, DATA = 0x80 cycles 1-4, rsp_valid cycle 5, ctrl_shadow = 0x80.
REQ-034 Read addr 1, bus model drives 0x5A during STROBE -> READ high 2 cycles, DATA never driven by DUT, rsp_rdata = 0x5A with rsp_valid.
REQ-035 Back-to-back write addr 0 0x11 then read addr 2 -> second accept coincides with first rsp_valid; strobes never overlap.
REQ-036 RESET asserted during STROBE of a write -> WRITE falls and DATA goes high-Z same cycle, no rsp_valid, ctrl_shadow = 0.
REQ-037 SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 -> strobe 1 cycle starting cycle 4, rsp_valid at cycle 7.
REQ-038 req_valid held during busy -> exactly one transfer per acceptance, none dropped or duplicated.

Source files
------------

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: host-side bus master for an 8255-style PPI.
// A host request is accepted while idle and played out as SETUP -> STROBE -> HOLD
// on the PPI pins. Completion is flagged by a one-cycle rsp_valid pulse.
//
// Ports
//   CLK, RESET              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_write/addr/wdata    transfer description, latched on acceptance
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               last read data, held until the next read completes
//   ctrl_shadow             last word written to the control register (address 3)
//   A, WRITE, READ, DATA    PPI address, strobes and tri-state data bus
//
// SETUP_CYC, STROBE_CYC and HOLD_CYC are legal in 1..15.
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] ctrl_shadow,
  output logic [1:0] A,
  output logic       WRITE,
  output logic       READ,
  inout  wire  [7:0] DATA
);

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(3);

  // Counters hold "cycles remaining minus one" so a phase ends when they reach zero.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  txn_t              txn_q, txn_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              drive_q, drive_d;
  logic              busy_d;

  // State, phase counter, latched transfer and registered pin/host outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      txn_q       <= '0;
      rdata_q     <= '0;
      ctrl_q      <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      a_q         <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txn_q       <= txn_d;
      rdata_q     <= rdata_d;
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      a_q         <= a_d;
      write_q     <= write_d;
      read_q      <= read_d;
      drive_q     <= drive_d;
    end
  end

  // Next-state, phase sequencing and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txn_d       = txn_q;
    rdata_d     = rdata_q;
    ctrl_d      = ctrl_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone means acceptance here.
        if (req_valid) begin
          state_d     = ST_SETUP;
          cnt_d       = SETUP_LOAD;
          txn_d.write = req_write;
          txn_d.addr  = req_addr;
          txn_d.wdata = req_wdata;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          // Read data is captured on the edge that ends the last strobe cycle.
          if (!txn_q.write) begin
            rdata_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          if (txn_q.write && (txn_q.addr == CTRL_ADDR)) begin
            ctrl_d = txn_q.wdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin outputs are registered from the next state so they line up with it.
    busy_d  = (state_d != ST_IDLE);
    ready_d = !busy_d;
    a_d     = busy_d ? txn_d.addr : '0;
    write_d = (state_d == ST_STROBE) && txn_d.write;
    read_d  = (state_d == ST_STROBE) && !txn_d.write;
    drive_d = busy_d && txn_d.write;
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign ctrl_shadow = ctrl_q;
  assign A           = a_q;
  assign WRITE       = write_q;
  assign READ        = read_q;
  assign DATA        = drive_q ? txn_q.wdata : {DATA_W{1'bz}};

endmodule
